// File: rtl/demux1x8_bank.sv
// demux1x8_bank: a 1-to-8 write demultiplexer into an 8-entry, 32-bit register bank.
// Single beats are steered by sel_i. A burst writes burst_len_i consecutive entries,
// starting at sel_i and wrapping modulo 8. A per-entry valid mask records which
// entries have been written since the last clear or reset.
module demux1x8_bank (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic [2:0]  sel_i,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        burst_start_i,
    input  logic [3:0]  burst_len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  wr_ptr_o,
    output logic [7:0]  valid_mask_o,
    output logic [31:0] out0_o,
    output logic [31:0] out1_o,
    output logic [31:0] out2_o,
    output logic [31:0] out3_o,
    output logic [31:0] out4_o,
    output logic [31:0] out5_o,
    output logic [31:0] out6_o,
    output logic [31:0] out7_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [7:0]  valid_mask_q, valid_mask_d;
    logic [31:0] entry_q [8];

    // Write port into the bank, shared by single writes and burst beats.
    logic        wr_en;
    logic [2:0]  wr_idx;

    logic        beat_acc;
    logic        len_legal;

    // Status outputs decoded from the registered state only.
    always_comb begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
            end
            StBurst: begin
                busy_o = 1'b1;
            end
            StDone: begin
                in_ready_o = 1'b0;
                busy_o     = 1'b1;
                done_o     = 1'b1;
            end
            default: begin
                in_ready_o = 1'b1;
            end
        endcase
    end

    // A beat is never taken while reset is asserted, so the handshake is gated here.
    assign beat_acc  = in_valid_i && in_ready_o && !reset_i;
    assign len_legal = (burst_len_i != 4'd0) && (burst_len_i <= 4'd8);

    // Next-state, write steering and burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        wr_en       = 1'b0;
        wr_idx      = sel_i;

        unique case (state_q)
            StIdle: begin
                if (burst_start_i && len_legal) begin
                    if (beat_acc) begin
                        // The simultaneous beat counts as the first burst beat.
                        wr_en       = 1'b1;
                        wr_idx      = sel_i;
                        wr_ptr_d    = sel_i + 3'd1;
                        remaining_d = burst_len_i - 4'd1;
                        state_d     = (burst_len_i == 4'd1) ? StDone : StBurst;
                    end else begin
                        wr_ptr_d    = sel_i;
                        remaining_d = burst_len_i;
                        state_d     = StBurst;
                    end
                end else if (beat_acc) begin
                    // Plain single write; an illegal burst request is simply dropped.
                    wr_en  = 1'b1;
                    wr_idx = sel_i;
                end
            end

            StBurst: begin
                // sel_i and burst_start_i are ignored; without a beat everything holds.
                if (beat_acc) begin
                    wr_en       = 1'b1;
                    wr_idx      = wr_ptr_q;
                    wr_ptr_d    = wr_ptr_q + 3'd1;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Valid mask: clear drops every bit, but the entry written this cycle stays set.
    always_comb begin
        valid_mask_d = clear_i ? 8'h00 : valid_mask_q;
        if (wr_en) begin
            valid_mask_d[wr_idx] = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            wr_ptr_q     <= 3'd0;
            remaining_q  <= 4'd0;
            valid_mask_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            remaining_q  <= remaining_d;
            valid_mask_q <= valid_mask_d;
        end
    end

    // Data bank: only the addressed entry is loaded on an accepted beat.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 8; i++) begin
                entry_q[i] <= 32'h0;
            end
        end else if (wr_en) begin
            entry_q[wr_idx] <= in_data_i;
        end
    end

    assign wr_ptr_o     = wr_ptr_q;
    assign valid_mask_o = valid_mask_q;

    assign out0_o = entry_q[0];
    assign out1_o = entry_q[1];
    assign out2_o = entry_q[2];
    assign out3_o = entry_q[3];
    assign out4_o = entry_q[4];
    assign out5_o = entry_q[5];
    assign out6_o = entry_q[6];
    assign out7_o = entry_q[7];

endmodule

// File: tb/tb_demux1x8_bank.sv
// Self-checking bench for demux1x8_bank: directed scenarios followed by random traffic.
// A behavioural model of the bank is compared against every output after every edge.
module tb_demux1x8_bank;

    logic        clk = 1'b0;
    logic        reset_i, clear_i, in_valid_i, burst_start_i;
    logic [2:0]  sel_i;
    logic [31:0] in_data_i;
    logic [3:0]  burst_len_i;
    logic        in_ready_o, busy_o, done_o;
    logic [2:0]  wr_ptr_o;
    logic [7:0]  valid_mask_o;
    logic [31:0] out0_o, out1_o, out2_o, out3_o, out4_o, out5_o, out6_o, out7_o;
    logic [31:0] dut_out [8];

    always #5 clk = ~clk;

    demux1x8_bank u_dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .sel_i         (sel_i),
        .in_data_i     (in_data_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .burst_start_i (burst_start_i),
        .burst_len_i   (burst_len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .wr_ptr_o      (wr_ptr_o),
        .valid_mask_o  (valid_mask_o),
        .out0_o        (out0_o),
        .out1_o        (out1_o),
        .out2_o        (out2_o),
        .out3_o        (out3_o),
        .out4_o        (out4_o),
        .out5_o        (out5_o),
        .out6_o        (out6_o),
        .out7_o        (out7_o)
    );

    assign dut_out[0] = out0_o;
    assign dut_out[1] = out1_o;
    assign dut_out[2] = out2_o;
    assign dut_out[3] = out3_o;
    assign dut_out[4] = out4_o;
    assign dut_out[5] = out5_o;
    assign dut_out[6] = out6_o;
    assign dut_out[7] = out7_o;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = burst in progress, 2 = burst just finished.
    int          m_mode;
    int          m_ptr;
    int          m_left;
    logic [31:0] m_mem [8];
    bit   [7:0]  m_mask;

    task automatic model_step();
        bit acc;
        int len;
        if (reset_i) begin
            m_mode = 0;
            m_ptr  = 0;
            m_left = 0;
            m_mask = 8'h00;
            for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
        end else begin
            acc = in_valid_i && (m_mode != 2);
            len = int'(burst_len_i);
            if (clear_i) m_mask = 8'h00;
            if (m_mode == 2) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                if (acc) begin
                    m_mem[m_ptr]  = in_data_i;
                    m_mask[m_ptr] = 1'b1;
                    m_ptr  = (m_ptr + 1) % 8;
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = 2;
                end
            end else if (burst_start_i && len >= 1 && len <= 8) begin
                if (acc) begin
                    m_mem[sel_i]  = in_data_i;
                    m_mask[sel_i] = 1'b1;
                    m_ptr  = (int'(sel_i) + 1) % 8;
                    m_left = len - 1;
                    m_mode = (m_left == 0) ? 2 : 1;
                end else begin
                    m_ptr  = int'(sel_i);
                    m_left = len;
                    m_mode = 1;
                end
            end else if (acc) begin
                m_mem[sel_i]  = in_data_i;
                m_mask[sel_i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check_eq({where, ".in_ready"}, 32'(in_ready_o), 32'(m_mode != 2));
        check_eq({where, ".busy"}, 32'(busy_o), 32'(m_mode != 0));
        check_eq({where, ".done"}, 32'(done_o), 32'(m_mode == 2));
        check_eq({where, ".wr_ptr"}, 32'(wr_ptr_o), 32'(m_ptr));
        check_eq({where, ".valid_mask"}, 32'(valid_mask_o), 32'(m_mask));
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s.out%0d", where, i), dut_out[i], m_mem[i]);
        end
    endtask

    // One clock: model and DUT both consume the inputs present at the edge.
    task automatic tick(input string where);
        @(posedge clk);
        model_step();
        #1;
        compare_all(where);
    endtask

    task automatic idle_inputs();
        reset_i       = 1'b0;
        clear_i       = 1'b0;
        in_valid_i    = 1'b0;
        burst_start_i = 1'b0;
        sel_i         = 3'd0;
        in_data_i     = 32'h0;
        burst_len_i   = 4'd0;
    endtask

    int done_seen;

    initial begin
        idle_inputs();
        reset_i = 1'b1;
        tick("reset0");
        tick("reset1");
        reset_i = 1'b0;
        check_eq("reset.mask", 32'(valid_mask_o), 32'h0);
        check_eq("reset.busy", 32'(busy_o), 32'h0);
        check_eq("reset.in_ready", 32'(in_ready_o), 32'h1);
        check_eq("reset.out0", out0_o, 32'h0);

        // Single writes.
        in_valid_i = 1'b1;
        sel_i      = 3'd3;
        in_data_i  = 32'hDEAD_BEEF;
        tick("single_a");
        sel_i      = 3'd7;
        in_data_i  = 32'h1234_5678;
        tick("single_b");
        idle_inputs();
        check_eq("single.out3", out3_o, 32'hDEAD_BEEF);
        check_eq("single.out7", out7_o, 32'h1234_5678);
        check_eq("single.mask", 32'(valid_mask_o), 32'h88);
        check_eq("single.busy", 32'(busy_o), 32'h0);

        // Wrapping burst of 4 from entry 6.
        clear_i = 1'b1;
        tick("wrap_clear");
        clear_i       = 1'b0;
        burst_start_i = 1'b1;
        sel_i         = 3'd6;
        burst_len_i   = 4'd4;
        tick("wrap_start");
        burst_start_i = 1'b0;
        check_eq("wrap.busy", 32'(busy_o), 32'h1);
        check_eq("wrap.ptr0", 32'(wr_ptr_o), 32'h6);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'hA0 + 32'(i);
            tick("wrap_beat");
            if (done_o) done_seen++;
        end
        check_eq("wrap.ptr_end", 32'(wr_ptr_o), 32'h2);
        idle_inputs();
        tick("wrap_tail");
        if (done_o) done_seen++;
        check_eq("wrap.done_count", 32'(done_seen), 32'h1);
        check_eq("wrap.out6", out6_o, 32'hA0);
        check_eq("wrap.out7", out7_o, 32'hA1);
        check_eq("wrap.out0", out0_o, 32'hA2);
        check_eq("wrap.out1", out1_o, 32'hA3);
        check_eq("wrap.mask", 32'(valid_mask_o), 32'hC3);

        // Stalled burst of 3 from entry 0, five idle cycles between beats.
        burst_start_i = 1'b1;
        sel_i         = 3'd0;
        burst_len_i   = 4'd3;
        tick("stall_start");
        burst_start_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid_i = 1'b0;
            for (int s = 0; s < 5; s++) begin
                tick("stall_gap");
                check_eq("stall.busy", 32'(busy_o), 32'h1);
                check_eq("stall.done", 32'(done_o), 32'h0);
                check_eq("stall.ptr", 32'(wr_ptr_o), 32'(b));
            end
            in_valid_i = 1'b1;
            in_data_i  = 32'hB0 + 32'(b);
            tick("stall_beat");
            check_eq("stall.done_after_beat", 32'(done_o), 32'(b == 2));
        end
        idle_inputs();
        tick("stall_tail");

        // Burst start with a length-1 beat in the same cycle.
        burst_start_i = 1'b1;
        sel_i         = 3'd2;
        burst_len_i   = 4'd1;
        in_valid_i    = 1'b1;
        in_data_i     = 32'h55;
        tick("simul");
        idle_inputs();
        check_eq("simul.out2", out2_o, 32'h55);
        check_eq("simul.done", 32'(done_o), 32'h1);
        check_eq("simul.in_ready", 32'(in_ready_o), 32'h0);
        tick("simul_tail");
        check_eq("simul.in_ready_back", 32'(in_ready_o), 32'h1);
        check_eq("simul.busy_back", 32'(busy_o), 32'h0);

        // Burst of 8 from entry 5 fills the bank and returns the pointer to 5.
        burst_start_i = 1'b1;
        sel_i         = 3'd5;
        burst_len_i   = 4'd8;
        in_valid_i    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data_i = 32'hC0 + 32'(i);
            tick("full_beat");
            burst_start_i = 1'b0;
        end
        idle_inputs();
        check_eq("full.mask", 32'(valid_mask_o), 32'hFF);
        check_eq("full.ptr", 32'(wr_ptr_o), 32'h5);
        check_eq("full.out4", out4_o, 32'hC7);
        tick("full_tail");

        // Clear together with a write keeps only the written bit.
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        sel_i      = 3'd4;
        in_data_i  = 32'h44;
        tick("clear_write");
        idle_inputs();
        check_eq("clear.mask", 32'(valid_mask_o), 32'h10);

        // Reset in the middle of a burst.
        burst_start_i = 1'b1;
        sel_i         = 3'd1;
        burst_len_i   = 4'd5;
        tick("abort_start");
        burst_start_i = 1'b0;
        in_valid_i    = 1'b1;
        in_data_i     = 32'hE1;
        tick("abort_beat");
        reset_i = 1'b1;
        tick("abort_reset");
        idle_inputs();
        check_eq("abort.busy", 32'(busy_o), 32'h0);
        check_eq("abort.mask", 32'(valid_mask_o), 32'h0);
        check_eq("abort.out1", out1_o, 32'h0);
        check_eq("abort.out4", out4_o, 32'h0);
        tick("abort_after");
        check_eq("abort.done", 32'(done_o), 32'h0);

        // Illegal lengths: 0 is dropped; 9 with a beat becomes a single write.
        burst_start_i = 1'b1;
        burst_len_i   = 4'd0;
        tick("len0");
        check_eq("len0.busy", 32'(busy_o), 32'h0);
        check_eq("len0.done", 32'(done_o), 32'h0);
        burst_len_i = 4'd9;
        in_valid_i  = 1'b1;
        sel_i       = 3'd6;
        in_data_i   = 32'h99;
        tick("len9");
        idle_inputs();
        check_eq("len9.busy", 32'(busy_o), 32'h0);
        check_eq("len9.out6", out6_o, 32'h99);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset_i       = ($urandom_range(0, 199) == 0);
            clear_i       = ($urandom_range(0, 24) == 0);
            in_valid_i    = ($urandom_range(0, 9) < 6);
            burst_start_i = ($urandom_range(0, 4) == 0);
            burst_len_i   = 4'($urandom_range(0, 15));
            sel_i         = 3'($urandom_range(0, 7));
            in_data_i     = $urandom;
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
